// File: rtl/div_unit.sv
// Iterative 32-bit restoring radix-2 divider for the execute stage.
// Fixed 33-cycle latency from request to div_complete; results held until accepted.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            es_div_enable,
    input  logic            es_mul_div_sign,
    input  logic [XLEN-1:0] es_rj_value,
    input  logic [XLEN-1:0] es_rkd_value,
    input  logic            div_accept,
    input  logic            div_flush,
    output logic            div_complete,
    output logic [XLEN-1:0] div_quotient,
    output logic [XLEN-1:0] div_remainder,
    output logic            div_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_dvd;      // dividend magnitude, shifts out as quotient bits shift in
    logic [XLEN-1:0]   r_dsr;
    logic [XLEN-1:0]   r_rem;
    logic [4:0]        r_cnt;
    logic              r_sign_q;
    logic              r_sign_r;
    logic              r_dz;
    logic [XLEN-1:0]   r_rj_raw;
    logic              r_complete;
    logic [XLEN-1:0]   r_quot;
    logic [XLEN-1:0]   r_remout;

    // Operand magnitudes at capture time
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;

    assign w_a_neg = es_mul_div_sign & es_rj_value[XLEN-1];
    assign w_b_neg = es_mul_div_sign & es_rkd_value[XLEN-1];
    assign w_a_abs = w_a_neg ? (~es_rj_value + 32'd1) : es_rj_value;
    assign w_b_abs = w_b_neg ? (~es_rkd_value + 32'd1) : es_rkd_value;

    // The remainder stays below the divisor, so the 33-bit partial remainder
    // only exists as the shifted value; one extra trial bit detects borrow.
    logic [XLEN:0]     w_shift;
    logic [XLEN+1:0]   w_trial;
    logic              w_qbit;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_q_nxt;
    logic [XLEN-1:0]   w_q_res;
    logic [XLEN-1:0]   w_r_res;

    assign w_shift   = {r_rem, r_dvd[XLEN-1]};
    assign w_trial   = {1'b0, w_shift} - {2'b00, r_dsr};
    assign w_qbit    = ~w_trial[XLEN+1];
    assign w_rem_nxt = w_qbit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_q_nxt   = {r_dvd[XLEN-2:0], w_qbit};
    assign w_q_res   = r_dz ? {XLEN{1'b1}} : (r_sign_q ? (~w_q_nxt + 32'd1) : w_q_nxt);
    assign w_r_res   = r_dz ? r_rj_raw : (r_sign_r ? (~w_rem_nxt + 32'd1) : w_rem_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_dz       <= 1'b0;
            r_rj_raw   <= '0;
            r_complete <= 1'b0;
            r_quot     <= '0;
            r_remout   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (es_div_enable && !div_flush) begin
                        r_state  <= BUSY;
                        r_dvd    <= w_a_abs;
                        r_dsr    <= w_b_abs;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_sign_q <= w_a_neg ^ w_b_neg;
                        r_sign_r <= w_a_neg;
                        r_dz     <= (es_rkd_value == '0);
                        r_rj_raw <= es_rj_value;
                    end
                end
                BUSY: begin
                    if (div_flush || !es_div_enable) begin
                        r_state    <= IDLE;
                        r_complete <= 1'b0;
                    end else begin
                        r_dvd <= w_q_nxt;
                        r_rem <= w_rem_nxt;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state    <= DONE;
                            r_complete <= 1'b1;
                            r_quot     <= w_q_res;
                            r_remout   <= w_r_res;
                        end
                    end
                end
                DONE: begin
                    // Flush outranks accept; both simply return to IDLE.
                    if (div_flush || div_accept) begin
                        r_state    <= IDLE;
                        r_complete <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_complete <= 1'b0;
                end
            endcase
        end
    end

    assign div_complete  = r_complete;
    assign div_quotient  = r_quot;
    assign div_remainder = r_remout;
    assign div_busy      = (r_state == BUSY);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, stall, flush, reset and back-to-back operation.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        es_div_enable;
    logic        es_mul_div_sign;
    logic [31:0] es_rj_value;
    logic [31:0] es_rkd_value;
    logic        div_accept;
    logic        div_flush;
    logic        div_complete;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_busy;

    int checks;
    int failures;

    div_unit #(.XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .es_div_enable  (es_div_enable),
        .es_mul_div_sign(es_mul_div_sign),
        .es_rj_value    (es_rj_value),
        .es_rkd_value   (es_rkd_value),
        .div_accept     (div_accept),
        .div_flush      (div_flush),
        .div_complete   (div_complete),
        .div_quotient   (div_quotient),
        .div_remainder  (div_remainder),
        .div_busy       (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise a request and count edges until div_complete is seen (-1 on timeout).
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int lat);
        @(negedge clk);
        es_mul_div_sign = sgn;
        es_rj_value     = a;
        es_rkd_value    = b;
        es_div_enable   = 1'b1;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (div_complete) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic accept_and_drop;
        @(negedge clk);
        div_accept    = 1'b1;
        es_div_enable = 1'b0;
        @(posedge clk);
        #1;
        div_accept = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (div_complete !== 1'b0 || div_busy !== 1'b0 || div_quotient !== 32'd0 || div_remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset: complete=%b busy=%b q=%h r=%h expected 0 0 0 0",
                     div_complete, div_busy, div_quotient, div_remainder);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_unsigned_basic;
        int lat;
        run_div(1'b0, 32'd100, 32'd7, lat);
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("FAIL u100/7 latency: got %0d expected 33", lat);
        end
        checks++;
        if (div_quotient !== 32'd14 || div_remainder !== 32'd2) begin
            failures++;
            $display("FAIL u100/7 result: q=%h r=%h expected q=0000000e r=00000002", div_quotient, div_remainder);
        end
        accept_and_drop();
        checks++;
        if (div_complete !== 1'b0 || div_busy !== 1'b0) begin
            failures++;
            $display("FAIL accept->idle: complete=%b busy=%b expected 0 0", div_complete, div_busy);
        end
    endtask

    task automatic test_signed;
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] eq [3];
        logic [31:0] er [3];
        int lat;
        va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;        eq[0] = 32'hFFFFFFFD; er[0] = 32'hFFFFFFFF;
        va[1] = 32'd7;        vb[1] = 32'hFFFFFFFE; eq[1] = 32'hFFFFFFFD; er[1] = 32'd1;
        va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; eq[2] = 32'h80000000; er[2] = 32'd0;
        for (int k = 0; k < 3; k++) begin
            run_div(1'b1, va[k], vb[k], lat);
            checks++;
            if (lat !== 33 || div_quotient !== eq[k] || div_remainder !== er[k]) begin
                failures++;
                $display("FAIL signed[%0d] %h/%h: lat=%0d q=%h r=%h expected lat=33 q=%h r=%h",
                         k, va[k], vb[k], lat, div_quotient, div_remainder, eq[k], er[k]);
            end
            accept_and_drop();
        end
    endtask

    task automatic test_div_zero;
        int lat;
        run_div(1'b1, 32'hFFFFFFF0, 32'd0, lat);
        checks++;
        if (lat !== 33 || div_quotient !== 32'hFFFFFFFF || div_remainder !== 32'hFFFFFFF0) begin
            failures++;
            $display("FAIL sdivzero: lat=%0d q=%h r=%h expected lat=33 q=ffffffff r=fffffff0",
                     lat, div_quotient, div_remainder);
        end
        accept_and_drop();
        run_div(1'b0, 32'd5, 32'd0, lat);
        checks++;
        if (lat !== 33 || div_quotient !== 32'hFFFFFFFF || div_remainder !== 32'd5) begin
            failures++;
            $display("FAIL udivzero: lat=%0d q=%h r=%h expected lat=33 q=ffffffff r=00000005",
                     lat, div_quotient, div_remainder);
        end
        accept_and_drop();
    endtask

    task automatic test_stall;
        int lat;
        int bad;
        bad = 0;
        run_div(1'b0, 32'd1000, 32'd33, lat);   // 30 r 10
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (div_complete !== 1'b1 || div_quotient !== 32'd30 || div_remainder !== 32'd10) bad++;
        end
        checks++;
        if (lat !== 33 || bad !== 0) begin
            failures++;
            $display("FAIL stall-hold: lat=%0d unstable_cycles=%0d q=%h r=%h expected lat=33 0 q=0000001e r=0000000a",
                     lat, bad, div_quotient, div_remainder);
        end
        accept_and_drop();
        checks++;
        if (div_complete !== 1'b0 || div_busy !== 1'b0) begin
            failures++;
            $display("FAIL stall-accept: complete=%b busy=%b expected 0 0", div_complete, div_busy);
        end
    endtask

    task automatic test_flush;
        logic [31:0] pq;
        logic [31:0] pr;
        int lat;
        pq = div_quotient;
        pr = div_remainder;
        @(negedge clk);
        es_mul_div_sign = 1'b0;
        es_rj_value     = 32'd77;
        es_rkd_value    = 32'd3;
        es_div_enable   = 1'b1;
        repeat (11) @(posedge clk);   // IDLE->BUSY edge plus 10 BUSY cycles
        #1;
        checks++;
        if (div_busy !== 1'b1) begin
            failures++;
            $display("FAIL flush-pre busy: got %b expected 1", div_busy);
        end
        @(negedge clk);
        div_flush = 1'b1;
        @(posedge clk);
        #1;
        div_flush     = 1'b0;
        es_div_enable = 1'b0;
        checks++;
        if (div_busy !== 1'b0 || div_complete !== 1'b0 || div_quotient !== pq || div_remainder !== pr) begin
            failures++;
            $display("FAIL flush-busy: busy=%b complete=%b q=%h r=%h expected 0 0 q=%h r=%h",
                     div_busy, div_complete, div_quotient, div_remainder, pq, pr);
        end
        // Flush together with accept while DONE
        run_div(1'b0, 32'd77, 32'd3, lat);
        @(negedge clk);
        div_flush     = 1'b1;
        div_accept    = 1'b1;
        es_div_enable = 1'b0;
        @(posedge clk);
        #1;
        div_flush  = 1'b0;
        div_accept = 1'b0;
        checks++;
        if (lat !== 33 || div_complete !== 1'b0 || div_busy !== 1'b0 || div_quotient !== 32'd25 || div_remainder !== 32'd2) begin
            failures++;
            $display("FAIL flush-done: lat=%0d complete=%b busy=%b q=%h r=%h expected 33 0 0 q=00000019 r=00000002",
                     lat, div_complete, div_busy, div_quotient, div_remainder);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_div(1'b0, 32'hFFFFFFFF, 32'd16, lat);
        checks++;
        if (lat !== 33 || div_quotient !== 32'h0FFFFFFF || div_remainder !== 32'd15) begin
            failures++;
            $display("FAIL b2b-first: lat=%0d q=%h r=%h expected 33 q=0fffffff r=0000000f",
                     lat, div_quotient, div_remainder);
        end
        @(negedge clk);
        div_accept      = 1'b1;
        es_mul_div_sign = 1'b1;
        es_rj_value     = 32'd50;
        es_rkd_value    = 32'hFFFFFFFB;
        @(posedge clk);
        #1;
        div_accept = 1'b0;
        checks++;
        if (div_busy !== 1'b0 || div_complete !== 1'b0) begin
            failures++;
            $display("FAIL b2b-idle-gap: busy=%b complete=%b expected 0 0", div_busy, div_complete);
        end
        @(posedge clk);
        #1;
        checks++;
        if (div_busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b-restart: busy=%b expected 1", div_busy);
        end
        @(negedge clk);
        es_rj_value  = 32'h12345678;   // must not disturb the running operation
        es_rkd_value = 32'd0;
        lat = -1;
        for (int i = 2; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (div_complete) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 33 || div_quotient !== 32'hFFFFFFF6 || div_remainder !== 32'd0) begin
            failures++;
            $display("FAIL b2b-second: lat=%0d q=%h r=%h expected 33 q=fffffff6 r=00000000",
                     lat, div_quotient, div_remainder);
        end
        accept_and_drop();
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        es_mul_div_sign = 1'b0;
        es_rj_value     = 32'd9;
        es_rkd_value    = 32'd2;
        es_div_enable   = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        es_div_enable = 1'b0;
        checks++;
        if (div_busy !== 1'b0 || div_complete !== 1'b0 || div_quotient !== 32'd0 || div_remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset-midop: busy=%b complete=%b q=%h r=%h expected 0 0 0 0",
                     div_busy, div_complete, div_quotient, div_remainder);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        es_div_enable   = 1'b0;
        es_mul_div_sign = 1'b0;
        es_rj_value     = '0;
        es_rkd_value    = '0;
        div_accept      = 1'b0;
        div_flush       = 1'b0;
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_div_zero();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
